// File: rtl/keypad_uart_tx.sv
// keypad_uart_tx: queues committed letters, word-submit and game-end codes
// from the keypad FSM and feeds them one byte at a time to the UART
// transmitter over the txdata/txclk/txready handshake.
module keypad_uart_tx #(
  parameter int unsigned DEPTH        = 8,
  parameter logic [7:0]  WORD_CODE    = 8'h0D,
  parameter logic [7:0]  END_CODE     = 8'h04,
  parameter logic [15:0] BUSY_TIMEOUT = 16'd1000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     letter_ready,
  input  logic [7:0]               letter_data,
  input  logic                     word_submit,
  input  logic                     game_end,
  input  logic                     txready,
  output logic [7:0]               txdata,
  output logic                     txclk,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     full,
  output logic                     overflow,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_STROBE    = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    state_q, state_d;
  logic [15:0]   tmo_q, tmo_d;
  logic [7:0]    txdata_q;
  logic          txclk_q, full_q, ovf_q, busy_q;

  logic          letter_ok, push_req, push_ok, collide, pop;
  logic [7:0]    push_byte;

  // Pick the single byte to enqueue this cycle and flag dropped requests
  always_comb begin
    letter_ok = letter_ready && (letter_data != 8'h00) && (letter_data != 8'h5F);
    push_req  = game_end || word_submit || letter_ok;
    push_byte = letter_data;
    if (word_submit) push_byte = WORD_CODE;
    if (game_end)    push_byte = END_CODE;
    collide   = (game_end && (word_submit || letter_ok)) || (word_submit && letter_ok);
    pop       = (state_q == S_LOAD);
    push_ok   = push_req && ((count_q != CW'(DEPTH)) || pop);
    count_d   = count_q + CW'(push_ok) - CW'(pop);
  end

  // Transmit sequencer next state; the timeout counter only runs in WAIT_BUSY
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE:      if ((count_q != '0) && txready) state_d = S_LOAD;
      S_LOAD:      state_d = S_STROBE;
      S_STROBE: begin
        state_d = S_WAIT_BUSY;
        tmo_d   = 16'd0;
      end
      S_WAIT_BUSY: begin
        if (!txready) begin
          state_d = S_WAIT_DONE;
        end else begin
          tmo_d = tmo_q + 16'd1;
          if (tmo_d == BUSY_TIMEOUT) state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: if (txready) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_byte;
  end

  // Pointers, occupancy, sequencer state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      tmo_q    <= 16'd0;
      txdata_q <= 8'h00;
      txclk_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        txdata_q <= mem_q[rd_ptr_q];
      end
      count_q <= count_d;
      state_q <= state_d;
      tmo_q   <= tmo_d;
      // Strobe is registered out of STROBE so it follows txdata by one cycle
      txclk_q <= (state_q == S_STROBE);
      full_q  <= (count_d == CW'(DEPTH));
      ovf_q   <= ovf_q || (push_req && !push_ok) || collide;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign txdata     = txdata_q;
  assign txclk      = txclk_q;
  assign fifo_count = count_q;
  assign full       = full_q;
  assign overflow   = ovf_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_keypad_uart_tx.sv
// Bench for keypad_uart_tx: transaction-level model (expected byte queue,
// sticky overflow) checked every cycle, plus directed literal checks.
module tb_keypad_uart_tx;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 100;

  logic       clk, reset;
  logic       letter_ready, word_submit, game_end, txready;
  logic [7:0] letter_data;
  logic [7:0] txdata;
  logic       txclk, full, overflow, busy;
  logic [3:0] fifo_count;

  logic uart_auto, uart_rdy, tr_man;
  assign txready = uart_auto ? uart_rdy : tr_man;

  keypad_uart_tx #(
    .DEPTH(DEPTH), .WORD_CODE(8'h0D), .END_CODE(8'h04), .BUSY_TIMEOUT(16'(TMO))
  ) dut (
    .clk(clk), .reset(reset), .letter_ready(letter_ready), .letter_data(letter_data),
    .word_submit(word_submit), .game_end(game_end), .txready(txready),
    .txdata(txdata), .txclk(txclk), .fifo_count(fifo_count), .full(full),
    .overflow(overflow), .busy(busy)
  );

  int checks = 0;
  int passes = 0;

  logic [7:0] q_exp[$];
  logic [7:0] sent[$];
  logic       m_ovf;
  logic       prev_txclk;
  int         m_strobes;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: accepted bytes in order, sticky overflow
  task automatic model_push(input logic ge, input logic ws, input logic lr, input logic [7:0] ld);
    logic lv, req, coll;
    logic [7:0] b;
    lv   = lr && (ld != 8'h00) && (ld != 8'h5F);
    req  = ge || ws || lv;
    coll = (ge && (ws || lv)) || (ws && lv);
    b    = ge ? 8'h04 : (ws ? 8'h0D : ld);
    if (req) begin
      if (q_exp.size() < DEPTH) q_exp.push_back(b);
      else m_ovf = 1'b1;
    end
    if (coll) m_ovf = 1'b1;
  endtask

  task automatic cyc(input logic ge, input logic ws, input logic lr, input logic [7:0] ld);
    game_end = ge; word_submit = ws; letter_ready = lr; letter_data = ld;
    @(posedge clk);
    model_push(ge, ws, lr, ld);
    #1;
    game_end = 1'b0; word_submit = 1'b0; letter_ready = 1'b0; letter_data = 8'h00;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_ovf = 1'b0;
    q_exp.delete();
    sent.delete();
    prev_txclk = 1'b0;
    m_strobes = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_sent(input string nm, input int n, input int budget);
    int k = 0;
    while (sent.size() < n && k < budget) begin
      idle();
      k++;
    end
    chk(nm, 32'(sent.size()), 32'(n));
  endtask

  // Per-cycle compare: overflow, strobe width and strobed byte order
  always @(negedge clk) begin
    if (!reset) begin
      chk("overflow", 32'(overflow), 32'(m_ovf));
      if (txclk) begin
        m_strobes++;
        chk("txclk_width", 32'(prev_txclk), 32'd0);
        if (q_exp.size() == 0) begin
          chk("strobe_pending", 32'd0, 32'd1);
        end else begin
          chk("strobe_byte", 32'(txdata), 32'(q_exp[0]));
          void'(q_exp.pop_front());
        end
        sent.push_back(txdata);
      end
      prev_txclk = txclk;
    end
  end

  // Simple UART: after a strobe, drop txready briefly, then recover
  always begin
    @(negedge clk);
    if (uart_auto && txclk) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      uart_rdy = 1'b0;
      repeat ($urandom_range(1, 10)) @(negedge clk);
      uart_rdy = 1'b1;
    end
  end

  initial begin
    logic [7:0] exp3 [4];
    int n, n2, k;
    logic ge, ws, lr;
    logic [7:0] ld;
    exp3 = '{8'h41, 8'h42, 8'h43, 8'h0D};
    reset = 1'b1; game_end = 1'b0; word_submit = 1'b0; letter_ready = 1'b0;
    letter_data = 8'h00; uart_auto = 1'b0; uart_rdy = 1'b1; tr_man = 1'b1;

    // 1: reset values and no spontaneous strobe
    do_reset();
    chk("rst_txdata", 32'(txdata), 32'h00);
    chk("rst_txclk", 32'(txclk), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (50) idle();
    chk("t1_no_strobe", 32'(m_strobes), 32'd0);

    // 2: single letter latency
    cyc(1'b0, 1'b0, 1'b1, 8'h41);
    idle();
    idle();
    chk("t2_txdata_n2", 32'(txdata), 32'h41);
    chk("t2_txclk_n2", 32'(txclk), 32'd0);
    idle();
    chk("t2_txclk_n3", 32'(txclk), 32'd1);
    idle();
    chk("t2_txclk_n4", 32'(txclk), 32'd0);
    tr_man = 1'b0;
    repeat (10) idle();
    tr_man = 1'b1;
    repeat (5) idle();
    chk("t2_busy_after", 32'(busy), 32'd0);
    chk("t2_count_after", 32'(fifo_count), 32'd0);

    // 3: queued order with txready held low
    tr_man = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 8'h41);
    cyc(1'b0, 1'b0, 1'b1, 8'h42);
    cyc(1'b0, 1'b0, 1'b1, 8'h43);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    idle();
    chk("t3_count4", 32'(fifo_count), 32'd4);
    sent.delete();
    uart_auto = 1'b1;
    wait_sent("t3_sent4", 4, 200);
    for (int i = 0; i < 4; i++)
      if (i < sent.size()) chk("t3_order", 32'(sent[i]), 32'(exp3[i]));
    repeat (30) idle();
    chk("t3_count0", 32'(fifo_count), 32'd0);

    // 4: overfill
    uart_auto = 1'b0; tr_man = 1'b0;
    chk("t4_idle_before", 32'(busy), 32'd0);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 1'b1, 8'(8'h41 + i));
    idle();
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_overflow", 32'(overflow), 32'd1);
    chk("t4_count8", 32'(fifo_count), 32'd8);
    sent.delete();
    uart_auto = 1'b1;
    wait_sent("t4_sent8", 8, 300);
    repeat (40) idle();
    chk("t4_no_ninth", 32'(sent.size()), 32'd8);
    if (sent.size() == 8) chk("t4_last", 32'(sent[7]), 32'h48);
    chk("t4_ovf_sticky", 32'(overflow), 32'd1);
    chk("t4_full_clear", 32'(full), 32'd0);

    // 5: blank letter ignored, priority collision
    uart_auto = 1'b0; tr_man = 1'b0;
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 8'h5F);
    idle();
    chk("t5_blank_count", 32'(fifo_count), 32'd0);
    chk("t5_blank_ovf", 32'(overflow), 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 8'h44);
    idle();
    chk("t5_coll_ovf", 32'(overflow), 32'd1);
    chk("t5_coll_count", 32'(fifo_count), 32'd1);
    sent.delete();
    uart_auto = 1'b1;
    wait_sent("t5_sent1", 1, 100);
    repeat (30) idle();
    chk("t5_only_one", 32'(sent.size()), 32'd1);
    if (sent.size() > 0) chk("t5_end_code", 32'(sent[0]), 32'h04);

    // Randomized traffic against the model; pushes gated so the FIFO never fills
    do_reset();
    uart_auto = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (q_exp.size() <= DEPTH - 3) begin
        ge = ($urandom_range(0, 99) < 4);
        ws = ($urandom_range(0, 99) < 8);
        lr = ($urandom_range(0, 99) < 30);
        k  = $urandom_range(0, 27);
        ld = (k == 26) ? 8'h00 : ((k == 27) ? 8'h5F : 8'(8'h41 + k));
        cyc(ge, ws, lr, ld);
      end else begin
        idle();
      end
    end
    k = 0;
    while (q_exp.size() != 0 && k < 500) begin
      idle();
      k++;
    end
    chk("rnd_drained", 32'(q_exp.size()), 32'd0);
    repeat (20) idle();
    chk("rnd_count0", 32'(fifo_count), 32'd0);
    chk("rnd_busy0", 32'(busy), 32'd0);

    // 6: timeout path, then reset during WAIT_DONE
    uart_auto = 1'b0; tr_man = 1'b1;
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 8'h58);
    cyc(1'b0, 1'b0, 1'b1, 8'h59);
    n = 0;
    while (!txclk && n < 50) begin
      idle();
      n++;
    end
    chk("t6_first_strobe", 32'(txclk), 32'd1);
    n2 = 0;
    do begin
      idle();
      n2++;
    end while (!txclk && n2 < int'(TMO) + 50);
    chk("t6_gap", 32'(n2), 32'(TMO + 3));
    chk("t6_second_byte", 32'(txdata), 32'h59);
    tr_man = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, 8'h5A);
    cyc(1'b0, 1'b0, 1'b1, 8'h5B);
    idle();
    chk("t6_wait_done_busy", 32'(busy), 32'd1);
    chk("t6_count2", 32'(fifo_count), 32'd2);
    #2;
    reset = 1'b1;
    m_ovf = 1'b0;
    q_exp.delete();
    #1;
    chk("t6_rst_txclk", 32'(txclk), 32'd0);
    chk("t6_rst_count", 32'(fifo_count), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_txdata", 32'(txdata), 32'h00);
    do_reset();
    tr_man = 1'b1;
    repeat (20) idle();
    chk("t6_post_quiet", 32'(m_strobes), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
